mul_batch_engine: RTL and testbench
===================================

MUL_BATCH_ENGINE -- requirements
Module: mul_batch_engine

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32: operand and result width in bits (8..64).
REQ-002 SHALL have parameter PIPELINE_STAGE, default 0: multiplier latency in cycles (0..8).
REQ-003 SHALL have parameter NUM_PAIRS, default 4: maximum operand pairs per line; 2*NUM_PAIRS*DATA_LEN <= 512.
REQ-004 clk  in  1  sole clock; all logic on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to run one batch.
REQ-007 soft_reset  in  1  abort and flush without a full reset.
REQ-008 count  in  8  number of pairs to process; latched when start is accepted.
REQ-009 rd_req  out  1  one-cycle request to read the input line.
REQ-010 rd_rsp_valid  in  1  input line present on rd_rsp_data.
REQ-011 rd_rsp_data  in  512  input line; pair i: a at [2i*DATA_LEN +: DATA_LEN], b at the next DATA_LEN bits.
REQ-012 wr_valid  out  1  output line valid; held until accepted.
REQ-013 wr_ready  in  1  consumer accepts wr_data when wr_valid && wr_ready.
REQ-014 wr_data  out  512  [31:0] status word; result i at [32 + i*DATA_LEN +: DATA_LEN]; unused bits 0.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, REQUEST, WAIT_RD, ISSUE, DRAIN, WRITE.
REQ-017 IDLE: start SHALL move to REQUEST; effective count = min(count, NUM_PAIRS) is latched.
REQ-018 REQUEST SHALL last exactly one cycle with rd_req=1, then move to WAIT_RD; rd_req SHALL be 0 in every other state.
REQ-019 WAIT_RD: on rd_rsp_valid the line SHALL be latched; next state is ISSUE, or WRITE if effective count is 0.
REQ-020 rd_rsp_valid outside WAIT_RD SHALL be ignored.
REQ-021 ISSUE SHALL present pair i to the multiplier on its i-th cycle, one pair per cycle, for effective-count cycles.
REQ-022 Multiplier operands SHALL be 0 whenever no pair is being issued.
REQ-023 The result of a pair issued in cycle t SHALL be captured into its slot at the end of cycle t+PIPELINE_STAGE.
- Tracking uses a valid/index shift register of depth PIPELINE_STAGE, not a fixed wait counter.
REQ-024 Results SHALL be the low DATA_LEN bits of the unsigned product.
REQ-025 After the last issue, the engine SHALL stay in DRAIN until the last capture, then enter WRITE.
- With PIPELINE_STAGE=0, ISSUE goes directly to WRITE.
REQ-026 WRITE: wr_valid=1 with wr_data stable; on wr_ready the next state is IDLE and wr_valid=0.
REQ-027 Status word: bit0=1; bits[15:8] = effective count; bits[7:1]=0; bits[31:16] per REQ-032.
REQ-028 start while busy SHALL be ignored.
REQ-029 soft_reset in any state SHALL, next cycle: enter IDLE, clear wr_valid, clear pipeline valids and result slots, and reset the multiplier.
- soft_reset wins over a simultaneous start.

Reset
REQ-030 On reset, the engine SHALL enter IDLE with all of the following 0: rd_req, wr_valid, wr_data, busy, latched count, pipeline valids.
- The multiplier reset is driven by reset || soft_reset.

Configuration
REQ-031 Macro MUL_BATCH_CYCLE_COUNT_EN SHALL compile in a 16-bit batch cycle counter.
REQ-032 With MUL_BATCH_CYCLE_COUNT_EN defined:
- The counter is cleared when start is accepted.
- It increments in every REQUEST, WAIT_RD, ISSUE and DRAIN cycle, saturating at 0xFFFF.
- Its value appears in status bits [31:16].
- Without the macro, bits [31:16]=0 and no counter logic exists.

Structure
REQ-033 Package mul_batch_pkg SHALL hold LINE_BITS=512, STATUS_BITS=32, the state enum typedef, and the lane-offset constants.
REQ-034 The datapath SHALL instantiate one sub-module, multiplier, with ports clk, reset, a, b, result and parameters DATA_LEN, PIPELINE_STAGE.

Verification
REQ-035 P=0, count=1, pair (7,6) -> wr_data[31:0]=0x00000101, [63:32]=42, all other bits 0.
REQ-036 P=3, count=4, pairs (1,2), (3,4), (0xFFFFFFFF,2), (0x10000,0x10000) -> results 2, 12, 0xFFFFFFFE, 0; status 0x0401.
REQ-037 Boundary counts:
- count=0 -> no issue cycles; write status 0x0001, all results 0.
- count=9 -> clamped to 4; status bits [15:8]=4.
REQ-038 wr_ready held low 5 cycles -> wr_valid and wr_data stable, busy=1, start pulses ignored; accepted on the 6th cycle, then IDLE.
REQ-039 soft_reset in the 2nd ISSUE cycle (P=3) -> IDLE next cycle, busy=0, no wr_valid; the following batch gives correct results.
REQ-040 Macro defined, P=2, count=2, rd_rsp_valid in the 10th WAIT_RD cycle -> status bits [31:16]=15.

Source files
------------

// File: rtl/mul_batch_pkg.sv
// Shared definitions for the batch multiply engine: line/status geometry,
// FSM state type and lane-offset helpers for the packed input line.
// Latency: n/a (package). Backpressure: n/a.
package mul_batch_pkg;

   localparam int LINE_BITS   = 512;
   localparam int STATUS_BITS = 32;
   localparam int IDX_W       = 8;

   // Status word field positions
   localparam int ST_DONE_BIT  = 0;
   localparam int ST_COUNT_LSB = 8;
   localparam int ST_CYC_LSB   = 16;

   // Results start right after the status word on the output line
   localparam int RESULT_BASE = STATUS_BITS;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQUEST,
      S_WAIT_RD,
      S_ISSUE,
      S_DRAIN,
      S_WRITE
   } state_t;

   // Pair idx on the input line: a then b, each dlen bits
   function automatic int a_lsb(input int idx, input int dlen);
      return 2 * idx * dlen;
   endfunction

   function automatic int b_lsb(input int idx, input int dlen);
      return (2 * idx + 1) * dlen;
   endfunction

endpackage

// File: rtl/mul_batch_engine_multiplier.sv
// Unsigned multiplier returning the low DATA_LEN bits of a*b.
// Latency: PIPELINE_STAGE cycles (0 = combinational). Backpressure: none, free-running.
// Ports: clk, reset (sync, active-high, clears pipeline), a, b in; result out.
module multiplier
   import mul_batch_pkg::*;
#(
   parameter int DATA_LEN       = 32,
   parameter int PIPELINE_STAGE = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_LEN-1:0] a,
   input  logic [DATA_LEN-1:0] b,
   output logic [DATA_LEN-1:0] result
);

   logic [DATA_LEN-1:0] w_prod;

   // Assignment context is DATA_LEN wide, so this is the truncated product
   assign w_prod = a * b;

   generate
      if (PIPELINE_STAGE == 0) begin : g_comb
         logic w_unused_ctl;
         assign w_unused_ctl = clk ^ reset;
         assign result = w_prod;
      end else begin : g_pipe
         logic [PIPELINE_STAGE-1:0][DATA_LEN-1:0] r_pipe;

         always_ff @(posedge clk) begin
            if (reset) begin
               r_pipe <= '0;
            end else begin
               r_pipe[0] <= w_prod;
               for (int k = 1; k < PIPELINE_STAGE; k++) begin
                  r_pipe[k] <= r_pipe[k-1];
               end
            end
         end

         assign result = r_pipe[PIPELINE_STAGE-1];
      end
   endgenerate

endmodule

// File: rtl/mul_batch_engine.sv
// Batch engine: reads one line of operand pairs, multiplies up to NUM_PAIRS pairs, writes one result line.
// Latency: start -> wr_valid = 3 + read wait + eff_count + (eff_count ? PIPELINE_STAGE : 0) cycles.
// Backpressure: wr_valid/wr_data held until wr_ready; start ignored while busy.
// Ports: clk, reset, start, soft_reset, count[7:0], rd_req, rd_rsp_valid, rd_rsp_data[511:0],
//        wr_valid, wr_ready, wr_data[511:0] (status [31:0], results above), busy.
// Optional: MUL_BATCH_CYCLE_COUNT_EN adds a 16-bit saturating batch cycle counter in status [31:16].
module mul_batch_engine
   import mul_batch_pkg::*;
#(
   parameter int DATA_LEN       = 32,
   parameter int PIPELINE_STAGE = 0,
   parameter int NUM_PAIRS      = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 soft_reset,
   input  logic [7:0]           count,
   output logic                 rd_req,
   input  logic                 rd_rsp_valid,
   input  logic [LINE_BITS-1:0] rd_rsp_data,
   output logic                 wr_valid,
   input  logic                 wr_ready,
   output logic [LINE_BITS-1:0] wr_data,
   output logic                 busy
);

   localparam int PAIR_BITS = 2 * NUM_PAIRS * DATA_LEN;
   localparam logic [IDX_W-1:0] MAX_CNT = IDX_W'(NUM_PAIRS);

   state_t                             r_state, w_state_nxt;
   logic [IDX_W-1:0]                   r_count, r_issue_idx;
   logic [IDX_W-1:0]                   w_count_eff, w_last_idx, w_cap_idx;
   logic [PAIR_BITS-1:0]               r_line;
   logic [NUM_PAIRS-1:0][DATA_LEN-1:0] r_slots;
   logic [NUM_PAIRS-1:0][DATA_LEN-1:0] w_lane_a, w_lane_b;
   logic [DATA_LEN-1:0]                w_mul_a, w_mul_b, w_mul_res;
   logic [STATUS_BITS-1:0]             w_status;
   logic [15:0]                        w_cyc;
   logic                               w_mul_rst, w_start_acc, w_issue;
   logic                               w_cap_vld, w_last_cap;

   assign w_mul_rst   = reset | soft_reset;
   assign w_start_acc = (r_state == S_IDLE) && start && !soft_reset;
   assign w_count_eff = (count > MAX_CNT) ? MAX_CNT : count;
   assign w_issue     = (r_state == S_ISSUE);
   assign w_last_idx  = r_count - IDX_W'(1);
   assign w_last_cap  = w_cap_vld && (w_cap_idx == w_last_idx);

   assign busy     = (r_state != S_IDLE);
   assign rd_req   = (r_state == S_REQUEST);
   assign wr_valid = (r_state == S_WRITE);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (w_mul_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_start_acc) w_state_nxt = S_REQUEST;
         S_REQUEST: w_state_nxt = S_WAIT_RD;
         S_WAIT_RD: if (rd_rsp_valid) w_state_nxt = (r_count == '0) ? S_WRITE : S_ISSUE;
         // Without a pipeline the last result lands in the same cycle it issues
         S_ISSUE:   if (r_issue_idx == w_last_idx)
                       w_state_nxt = (PIPELINE_STAGE == 0) ? S_WRITE : S_DRAIN;
         S_DRAIN:   if (w_last_cap) w_state_nxt = S_WRITE;
         S_WRITE:   if (wr_ready) w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (w_mul_rst) begin
         r_count     <= '0;
         r_issue_idx <= '0;
         r_line      <= '0;
         r_slots     <= '0;
      end else begin
         if (w_start_acc) begin
            r_count <= w_count_eff;
            r_slots <= '0;
         end
         if ((r_state == S_WAIT_RD) && rd_rsp_valid) begin
            r_line <= rd_rsp_data[PAIR_BITS-1:0];
         end
         r_issue_idx <= w_issue ? (r_issue_idx + IDX_W'(1)) : '0;
         for (int i = 0; i < NUM_PAIRS; i++) begin
            if (w_cap_vld && (w_cap_idx == IDX_W'(i))) begin
               r_slots[i] <= w_mul_res;
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_PAIRS; i++) begin : g_lane
      assign w_lane_a[i] = r_line[a_lsb(i, DATA_LEN) +: DATA_LEN];
      assign w_lane_b[i] = r_line[b_lsb(i, DATA_LEN) +: DATA_LEN];
   end

   // Operands are forced to zero outside issue cycles
   always_comb begin
      w_mul_a = '0;
      w_mul_b = '0;
      if (w_issue) begin
         for (int i = 0; i < NUM_PAIRS; i++) begin
            if (r_issue_idx == IDX_W'(i)) begin
               w_mul_a = w_lane_a[i];
               w_mul_b = w_lane_b[i];
            end
         end
      end
   end

   multiplier #(
      .DATA_LEN       (DATA_LEN),
      .PIPELINE_STAGE (PIPELINE_STAGE)
   ) u_mul (
      .clk    (clk),
      .reset  (w_mul_rst),
      .a      (w_mul_a),
      .b      (w_mul_b),
      .result (w_mul_res)
   );

   // Valid/index tracker that travels alongside the multiplier pipeline
   generate
      if (PIPELINE_STAGE == 0) begin : g_trk_comb
         assign w_cap_vld = w_issue;
         assign w_cap_idx = r_issue_idx;
      end else begin : g_trk_pipe
         logic [PIPELINE_STAGE-1:0]            r_vld_sr;
         logic [PIPELINE_STAGE-1:0][IDX_W-1:0] r_idx_sr;

         always_ff @(posedge clk) begin
            if (w_mul_rst) begin
               r_vld_sr <= '0;
               r_idx_sr <= '0;
            end else begin
               r_vld_sr[0] <= w_issue;
               r_idx_sr[0] <= r_issue_idx;
               for (int k = 1; k < PIPELINE_STAGE; k++) begin
                  r_vld_sr[k] <= r_vld_sr[k-1];
                  r_idx_sr[k] <= r_idx_sr[k-1];
               end
            end
         end

         assign w_cap_vld = r_vld_sr[PIPELINE_STAGE-1];
         assign w_cap_idx = r_idx_sr[PIPELINE_STAGE-1];
      end

      // Line bits above the configured lanes carry no operands
      if (PAIR_BITS < LINE_BITS) begin : g_line_hi
         logic w_unused_line_hi;
         assign w_unused_line_hi = ^rd_rsp_data[LINE_BITS-1:PAIR_BITS];
      end
   endgenerate

   // ------------------------------------------------------ cycle counter
`ifdef MUL_BATCH_CYCLE_COUNT_EN
   logic [15:0] r_cyc;

   always_ff @(posedge clk) begin
      if (w_mul_rst || w_start_acc) begin
         r_cyc <= '0;
      end else if ((r_state inside {S_REQUEST, S_WAIT_RD, S_ISSUE, S_DRAIN}) &&
                   (r_cyc != 16'hFFFF)) begin
         r_cyc <= r_cyc + 16'd1;
      end
   end

   assign w_cyc = r_cyc;
`else
   assign w_cyc = '0;
`endif

   // ------------------------------------------------------- output line
   always_comb begin
      w_status                          = '0;
      w_status[ST_DONE_BIT]             = 1'b1;
      w_status[ST_COUNT_LSB +: IDX_W]   = r_count;
      w_status[ST_CYC_LSB +: 16]        = w_cyc;
   end

   // Driven only in WRITE so the line reads zero from reset onward
   always_comb begin
      wr_data = '0;
      if (r_state == S_WRITE) begin
         wr_data[STATUS_BITS-1:0]                     = w_status;
         wr_data[RESULT_BASE +: NUM_PAIRS * DATA_LEN] = r_slots;
      end
   end

endmodule

// File: tb/tb_mul_batch_engine.sv
// Bench for mul_batch_engine: two instances (PIPELINE_STAGE 0 and 3) driven batch by batch;
// expected outputs derive from each batch's timeline and a plain-arithmetic result model.
// Optional: MUL_BATCH_CYCLE_COUNT_EN adds the cycle count to the expected status word.
module tb_mul_batch_engine;

   localparam int DL   = 32;
   localparam int NP   = 4;
   localparam int NDUT = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic         start_s [NDUT];
   logic         soft_s  [NDUT];
   logic [7:0]   count_s [NDUT];
   logic         rdreq_s [NDUT];
   logic         rdv_s   [NDUT];
   logic [511:0] rdd_s   [NDUT];
   logic         wv_s    [NDUT];
   logic         wrdy_s  [NDUT];
   logic [511:0] wd_s    [NDUT];
   logic         busy_s  [NDUT];

   bit           exp_busy [NDUT];
   bit           exp_rd   [NDUT];
   bit           exp_wv   [NDUT];
   logic [511:0] exp_dat  [NDUT];
   bit           chk_en = 1'b0;
   logic [511:0] last_wr;

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      mul_batch_engine #(
         .DATA_LEN       (DL),
         .PIPELINE_STAGE ((g == 0) ? 0 : 3),
         .NUM_PAIRS      (NP)
      ) u_dut (
         .clk          (clk),
         .reset        (reset),
         .start        (start_s[g]),
         .soft_reset   (soft_s[g]),
         .count        (count_s[g]),
         .rd_req       (rdreq_s[g]),
         .rd_rsp_valid (rdv_s[g]),
         .rd_rsp_data  (rdd_s[g]),
         .wr_valid     (wv_s[g]),
         .wr_ready     (wrdy_s[g]),
         .wr_data      (wd_s[g]),
         .busy         (busy_s[g])
      );
   end

   function automatic int pst(input int g);
      return (g == 0) ? 0 : 3;
   endfunction

   task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   function automatic logic [511:0] rand_line();
      logic [511:0] l;
      for (int j = 0; j < 16; j++) l[32*j +: 32] = $urandom;
      return l;
   endfunction

   // Expected output line: status plus the truncated product of each processed pair
   function automatic logic [511:0] model_line(input logic [511:0] line, input int ne);
      logic [511:0] m;
      logic [31:0]  a, b, p;
      m       = '0;
      m[0]    = 1'b1;
      m[15:8] = 8'(ne);
      for (int i = 0; i < ne; i++) begin
         a = line[64*i +: 32];
         b = line[64*i + 32 +: 32];
         p = a * b;
         m[32 + 32*i +: 32] = p;
      end
      return m;
   endfunction

   // Every cycle: compare all instances against what the current batch timeline demands
   always @(negedge clk) begin
      if (chk_en) begin
         for (int g = 0; g < NDUT; g++) begin
            chk($sformatf("dut%0d busy", g),   512'(busy_s[g]),  512'(exp_busy[g]));
            chk($sformatf("dut%0d rd_req", g), 512'(rdreq_s[g]), 512'(exp_rd[g]));
            chk($sformatf("dut%0d wr_valid", g), 512'(wv_s[g]),  512'(exp_wv[g]));
            if (exp_wv[g]) chk($sformatf("dut%0d wr_data", g), wd_s[g], exp_dat[g]);
         end
      end
   end

   task automatic idle(input int g, input int n);
      for (int k = 0; k < n; k++) begin
         start_s[g]  = 1'b0;
         soft_s[g]   = 1'b0;
         count_s[g]  = 8'($urandom);
         rdv_s[g]    = 1'($urandom_range(1));
         rdd_s[g]    = rand_line();
         wrdy_s[g]   = 1'($urandom_range(1));
         exp_busy[g] = 1'b0;
         exp_rd[g]   = 1'b0;
         exp_wv[g]   = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   // One batch; cycle k=0 is the start cycle. Response arrives after w empty WAIT_RD cycles,
   // wr_ready held low r cycles, soft_reset asserted in cycle 'abort' (negative = never).
   task automatic run_batch(input int g, input int cnt, input logic [511:0] line,
                            input int w, input int r, input int abort);
      int ne, d, k_rsp, k_wr, t;
      ne    = (cnt > NP) ? NP : cnt;
      d     = ne + ((ne > 0) ? pst(g) : 0);
      k_rsp = 2 + w;
      k_wr  = k_rsp + d + 1;
      t     = k_wr + r + 1;
      exp_dat[g] = model_line(line, ne);
`ifdef MUL_BATCH_CYCLE_COUNT_EN
      exp_dat[g][31:16] = 16'(1 + (w + 1) + d);
`endif
      last_wr = '0;
      for (int k = 0; k < t; k++) begin
         start_s[g]  = (k == 0) ? 1'b1 : ($urandom_range(3) == 0);
         count_s[g]  = (k == 0) ? 8'(cnt) : 8'($urandom);
         rdv_s[g]    = (k == k_rsp) ? 1'b1 :
                       ((k < 2 || k > k_rsp) ? 1'($urandom_range(1)) : 1'b0);
         rdd_s[g]    = (k == k_rsp) ? line : rand_line();
         wrdy_s[g]   = (k < k_wr) ? 1'($urandom_range(1)) : (k == t - 1);
         soft_s[g]   = (k == abort);
         exp_busy[g] = (k > 0);
         exp_rd[g]   = (k == 1);
         exp_wv[g]   = (k >= k_wr);
         @(negedge clk);
         if (exp_wv[g]) last_wr = wd_s[g];
         @(posedge clk); #1;
         if (k == abort) break;
      end
      idle(g, 2);
   endtask

   initial begin : watchdog
      #2_000_000;
      errors++;
      $display("FAIL watchdog timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

   initial begin : main
      logic [511:0] l35, l36;
      int cnt, w, r, ab;
      for (int g = 0; g < NDUT; g++) begin
         start_s[g] = 1'b0; soft_s[g] = 1'b0; count_s[g] = '0;
         rdv_s[g] = 1'b0; rdd_s[g] = '0; wrdy_s[g] = 1'b0;
         exp_busy[g] = 1'b0; exp_rd[g] = 1'b0; exp_wv[g] = 1'b0; exp_dat[g] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
         chk($sformatf("dut%0d reset busy", g),  512'(busy_s[g]),  '0);
         chk($sformatf("dut%0d reset rd_req", g), 512'(rdreq_s[g]), '0);
         chk($sformatf("dut%0d reset wr_valid", g), 512'(wv_s[g]), '0);
         chk($sformatf("dut%0d reset wr_data", g), wd_s[g], '0);
      end
      @(posedge clk); #1;
      reset  = 1'b0;
      chk_en = 1'b1;
      idle(0, 2);

      for (int g = 0; g < NDUT; g++) begin
         // count=1, pair (7,6); other lanes carry junk that must not appear
         l35 = rand_line();
         l35[63:0] = {32'd6, 32'd7};
         run_batch(g, 1, l35, 0, 0, -1);
         chk($sformatf("dut%0d one-pair status", g), 512'(last_wr[15:0]), 512'(16'h0101));
         chk($sformatf("dut%0d one-pair result", g), 512'(last_wr[63:32]), 512'(32'd42));
         chk($sformatf("dut%0d one-pair upper", g), 512'(last_wr[511:64]), '0);

         // four pairs including truncation cases
         l36 = rand_line();
         l36[63:0]    = {32'd2, 32'd1};
         l36[127:64]  = {32'd4, 32'd3};
         l36[191:128] = {32'd2, 32'hFFFF_FFFF};
         l36[255:192] = {32'h0001_0000, 32'h0001_0000};
         run_batch(g, 4, l36, 2, 0, -1);
         chk($sformatf("dut%0d four-pair status", g), 512'(last_wr[15:0]), 512'(16'h0401));
         chk($sformatf("dut%0d four-pair r0", g), 512'(last_wr[63:32]),   512'(32'd2));
         chk($sformatf("dut%0d four-pair r1", g), 512'(last_wr[95:64]),   512'(32'd12));
         chk($sformatf("dut%0d four-pair r2", g), 512'(last_wr[127:96]),  512'(32'hFFFF_FFFE));
         chk($sformatf("dut%0d four-pair r3", g), 512'(last_wr[159:128]), 512'(32'd0));

         // count=0: straight to WRITE with no results
         run_batch(g, 0, rand_line(), 1, 0, -1);
         chk($sformatf("dut%0d zero status", g), 512'(last_wr[15:0]), 512'(16'h0001));
         chk($sformatf("dut%0d zero results", g), 512'(last_wr[511:32]), '0);

         // count=9 is clamped to NUM_PAIRS
         run_batch(g, 9, rand_line(), 0, 0, -1);
         chk($sformatf("dut%0d clamp count", g), 512'(last_wr[15:8]), 512'(8'd4));

         // wr_ready low for 5 cycles, start pulses in between
         run_batch(g, 3, rand_line(), 1, 5, -1);

         // soft_reset in the 2nd ISSUE cycle, then a clean batch
         run_batch(g, 4, l36, 0, 0, 4);
         run_batch(g, 4, l36, 0, 0, -1);
         chk($sformatf("dut%0d post-abort r2", g), 512'(last_wr[127:96]), 512'(32'hFFFF_FFFE));
         chk($sformatf("dut%0d post-abort status", g), 512'(last_wr[15:0]), 512'(16'h0401));

`ifdef MUL_BATCH_CYCLE_COUNT_EN
         // response in the 10th WAIT_RD cycle, two pairs: 1 + 10 + 2 + P cycles
         run_batch(g, 2, rand_line(), 9, 0, -1);
         chk($sformatf("dut%0d cycle count", g), 512'(last_wr[31:16]),
             (g == 0) ? 512'(16'd13) : 512'(16'd16));
`endif

         // randomized batches, some with soft_reset at an arbitrary cycle
         for (int n = 0; n < 30; n++) begin
            cnt = ($urandom_range(7) == 0) ? int'($urandom_range(255)) : int'($urandom_range(5));
            w   = int'($urandom_range(4));
            r   = int'($urandom_range(3));
            ab  = ($urandom_range(5) == 0) ? int'($urandom_range(14)) : -1;
            run_batch(g, cnt, rand_line(), w, r, ab);
         end
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
